// File: rtl/i2c_phy_master.sv
// ---------------------------------------------------------------------------
// i2c_phy_master
//
// Bit-level I2C bus driver (transmit side of the bus PHY).  Executes one
// command at a time (START / repeated START, STOP, WRITE bit, READ bit) by
// sequencing the open-drain enables scl_o / sda_o.  The bus state is read back
// through the receiver's filtered scl_i / sda_i.  This lets the block follow
// clock stretching by slaves and detect lost arbitration.
//
// Ports:
//   clk, rstn          system clock, asynchronous active-low reset
//   cmd_valid/ready    command handshake, ready only while idle
//   cmd                00 START, 01 STOP, 10 WRITE, 11 READ
//   cmd_din            bit to drive for WRITE, captured at acceptance
//   done               one-cycle pulse, command completed
//   dout               bit sampled on SDA at the end of a READ/WRITE
//   al                 one-cycle pulse, arbitration lost
//   bus_owner          this master holds the bus (START done, no STOP/al since)
//   t_half_low         half of the SCL low period, clk cycles
//   t_high             SCL high period and START/STOP setup/hold, clk cycles
//   bus_busy           bus busy flag from the receiver
//   scl_i, sda_i       filtered bus lines from the receiver
//   scl_o, sda_o       1 = release line, 0 = pull low
// ---------------------------------------------------------------------------
module i2c_phy_master #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd,
    input  logic             cmd_din,
    output logic             done,
    output logic             dout,
    output logic             al,
    output logic             bus_owner,
    input  logic [CNT_W-1:0] t_half_low,
    input  logic [CNT_W-1:0] t_high,
    input  logic             bus_busy,
    input  logic             scl_i,
    input  logic             sda_i,
    output logic             scl_o,
    output logic             sda_o
);

    localparam logic [1:0] CMD_START = 2'b00;
    localparam logic [1:0] CMD_STOP  = 2'b01;
    localparam logic [1:0] CMD_WRITE = 2'b10;
    localparam logic [1:0] CMD_READ  = 2'b11;

    typedef enum logic [3:0] {
        S_IDLE,
        S_ST1,      // SCL low, SDA released (repeated START only)
        S_ST2,      // wait-high with SDA released
        S_ST3,      // SDA falls while SCL high: the START condition
        S_ST4,      // SCL pulled low after START hold
        S_SP1,      // SCL low, SDA low
        S_SP2,      // wait-high with SDA low
        S_SP3,      // SDA rises while SCL high: the STOP condition
        S_B1,       // SCL low, SDA held from the previous bit
        S_B2,       // SCL low, SDA set up with the new bit
        S_B3        // wait-high, SDA stable, sampled on the last cycle
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             scl_nxt, sda_nxt;
    logic             done_nxt, al_nxt, dout_nxt, owner_nxt;
    logic             din_q, din_nxt;
    logic             is_read, is_read_nxt;
    logic             counted;
    logic             phase_last;
    logic             accept;

    // A programmed length of zero still gives a one-cycle phase.
    function automatic logic [CNT_W-1:0] phase_len(input logic [CNT_W-1:0] t);
        return (t == '0) ? CNT_W'(1) : t;
    endfunction

    // done/al pulses fall in an IDLE cycle; holding ready low there keeps a
    // new command from being accepted in the same cycle as a completion.
    assign cmd_ready = (state == S_IDLE) && !done && !al;
    assign accept    = cmd_valid && cmd_ready;

    // State and output registers.  Reset releases both lines immediately.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= S_IDLE;
            cnt       <= '0;
            scl_o     <= 1'b1;
            sda_o     <= 1'b1;
            done      <= 1'b0;
            al        <= 1'b0;
            dout      <= 1'b0;
            bus_owner <= 1'b0;
            din_q     <= 1'b0;
            is_read   <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            scl_o     <= scl_nxt;
            sda_o     <= sda_nxt;
            done      <= done_nxt;
            al        <= al_nxt;
            dout      <= dout_nxt;
            bus_owner <= owner_nxt;
            din_q     <= din_nxt;
            is_read   <= is_read_nxt;
        end
    end

    // Next-state and output logic.  Every phase transition loads the
    // counter with the length of the phase being entered.  The timing inputs
    // are therefore sampled at phase entry only.  In the wait-high phases a
    // cycle only counts once the bus actually shows SCL high.  This is how
    // clock stretching by a slave extends the phase.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        scl_nxt     = scl_o;
        sda_nxt     = sda_o;
        done_nxt    = 1'b0;
        al_nxt      = 1'b0;
        dout_nxt    = dout;
        owner_nxt   = bus_owner;
        din_nxt     = din_q;
        is_read_nxt = is_read;

        counted = 1'b1;
        if (state inside {S_ST2, S_SP2, S_B3}) begin
            counted = scl_i;
        end
        phase_last = counted && (cnt <= CNT_W'(1));

        if ((state != S_IDLE) && counted && !phase_last) begin
            cnt_nxt = cnt - CNT_W'(1);
        end

        case (state)
            S_IDLE: begin
                if (accept) begin
                    din_nxt = cmd_din;
                    case (cmd)
                        CMD_START: begin
                            if (!bus_owner && bus_busy) begin
                                // Someone else owns the bus: give up at once.
                                al_nxt = 1'b1;
                            end else if (!scl_o) begin
                                // Repeated START: release SDA while SCL is low.
                                state_nxt = S_ST1;
                                scl_nxt   = 1'b0;
                                sda_nxt   = 1'b1;
                                cnt_nxt   = phase_len(t_half_low);
                            end else begin
                                state_nxt = S_ST2;
                                scl_nxt   = 1'b1;
                                sda_nxt   = 1'b1;
                                cnt_nxt   = phase_len(t_high);
                            end
                        end
                        CMD_STOP: begin
                            state_nxt = S_SP1;
                            scl_nxt   = 1'b0;
                            sda_nxt   = 1'b0;
                            cnt_nxt   = phase_len(t_half_low);
                        end
                        default: begin
                            // WRITE and READ share the bit sequence.
                            state_nxt   = S_B1;
                            is_read_nxt = (cmd == CMD_READ);
                            scl_nxt     = 1'b0;
                            cnt_nxt     = phase_len(t_half_low);
                        end
                    endcase
                end
            end

            S_ST1: begin
                if (phase_last) begin
                    state_nxt = S_ST2;
                    scl_nxt   = 1'b1;
                    cnt_nxt   = phase_len(t_high);
                end
            end

            S_ST2: begin
                if (phase_last) begin
                    state_nxt = S_ST3;
                    sda_nxt   = 1'b0;
                    cnt_nxt   = phase_len(t_high);
                end
            end

            S_ST3: begin
                if (phase_last) begin
                    state_nxt = S_ST4;
                    scl_nxt   = 1'b0;
                    cnt_nxt   = phase_len(t_half_low);
                end
            end

            S_ST4: begin
                if (phase_last) begin
                    state_nxt = S_IDLE;
                    done_nxt  = 1'b1;
                    owner_nxt = 1'b1;
                end
            end

            S_SP1: begin
                if (phase_last) begin
                    state_nxt = S_SP2;
                    scl_nxt   = 1'b1;
                    cnt_nxt   = phase_len(t_high);
                end
            end

            S_SP2: begin
                if (phase_last) begin
                    state_nxt = S_SP3;
                    sda_nxt   = 1'b1;
                    cnt_nxt   = phase_len(t_high);
                end
            end

            S_SP3: begin
                // SDA must read back high while the STOP condition is held.
                if (!sda_i) begin
                    state_nxt = S_IDLE;
                    al_nxt    = 1'b1;
                    scl_nxt   = 1'b1;
                    sda_nxt   = 1'b1;
                    owner_nxt = 1'b0;
                end else if (phase_last) begin
                    state_nxt = S_IDLE;
                    done_nxt  = 1'b1;
                    owner_nxt = 1'b0;
                end
            end

            S_B1: begin
                if (phase_last) begin
                    state_nxt = S_B2;
                    sda_nxt   = is_read ? 1'b1 : din_q;
                    cnt_nxt   = phase_len(t_half_low);
                end
            end

            S_B2: begin
                if (phase_last) begin
                    state_nxt = S_B3;
                    scl_nxt   = 1'b1;
                    cnt_nxt   = phase_len(t_high);
                end
            end

            S_B3: begin
                // A released SDA that reads low on a WRITE means another
                // master is driving a 0.  A READ expects exactly that.
                if (counted && !is_read && sda_o && !sda_i) begin
                    state_nxt = S_IDLE;
                    al_nxt    = 1'b1;
                    scl_nxt   = 1'b1;
                    sda_nxt   = 1'b1;
                    owner_nxt = 1'b0;
                end else if (phase_last) begin
                    state_nxt = S_IDLE;
                    dout_nxt  = sda_i;
                    scl_nxt   = 1'b0;
                    done_nxt  = 1'b1;
                end
            end

            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_i2c_phy_master.sv
// ---------------------------------------------------------------------------
// tb_i2c_phy_master
//
// Directed bench for i2c_phy_master.  The bus is modelled as a wired-AND of
// the DUT enables with a slave that can stretch SCL and pull SDA low.  Each
// command records the per-cycle (scl_o, sda_o) waveform and compares it with a
// hand-written expected waveform.  The expected completion event (done or al,
// dout, bus_owner) is queued when the command is issued.  A monitor pops that
// expectation whenever the DUT raises done or al.
// ---------------------------------------------------------------------------
module tb_i2c_phy_master;

    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rstn = 1'b0;
    logic             cmd_valid = 1'b0;
    logic [1:0]       cmd = 2'b00;
    logic             cmd_din = 1'b0;
    logic [CNT_W-1:0] t_half_low = 16'd4;
    logic [CNT_W-1:0] t_high = 16'd8;
    logic             bus_busy = 1'b0;
    logic             stretch = 1'b0;
    logic             resp_low = 1'b0;

    logic cmd_ready, done, dout, al, bus_owner, scl_o, sda_o;
    logic scl_i, sda_i;

    assign scl_i = scl_o & ~stretch;
    assign sda_i = sda_o & ~resp_low;

    i2c_phy_master #(.CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd        (cmd),
        .cmd_din    (cmd_din),
        .done       (done),
        .dout       (dout),
        .al         (al),
        .bus_owner  (bus_owner),
        .t_half_low (t_half_low),
        .t_high     (t_high),
        .bus_busy   (bus_busy),
        .scl_i      (scl_i),
        .sda_i      (sda_i),
        .scl_o      (scl_o),
        .sda_o      (sda_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        string name;
        logic  is_al;
        logic  chk_dout;
        logic  dout;
        logic  owner;
    } exp_t;

    exp_t       sb[$];
    logic [1:0] trace[$];
    logic [1:0] exp_tr[$];
    int         total = 0;
    int         bad = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s: got %0d want %0d", name, act, req);
        end
    endtask

    task automatic seg(input logic scl, input logic sda, input int n);
        repeat (n) exp_tr.push_back({scl, sda});
    endtask

    // Compare the recorded waveform with the expected one, then clear it.
    task automatic checkTrace(input string name);
        int n_diff;
        n_diff = 0;
        checkOutput({name, "_len"}, trace.size(), exp_tr.size());
        for (int i = 0; i < trace.size() && i < exp_tr.size(); i++) begin
            if (trace[i] !== exp_tr[i]) n_diff++;
        end
        checkOutput({name, "_wave_diffs"}, n_diff, 0);
        exp_tr.delete();
    endtask

    // Issue one command.  With collect set, record the waveform from the
    // first phase cycle up to and including the done/al cycle.
    task automatic applyStimulus(input string name, input logic [1:0] c, input logic d,
                                 input logic collect, input logic is_al,
                                 input logic chk_dout, input logic exp_dout,
                                 input logic exp_owner);
        exp_t e;
        int   k;
        k = 0;
        while (!cmd_ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        checkOutput({name, "_ready"}, cmd_ready, 1);
        if (collect) begin
            e.name = name; e.is_al = is_al; e.chk_dout = chk_dout;
            e.dout = exp_dout; e.owner = exp_owner;
            sb.push_back(e);
        end
        cmd_valid = 1'b1;
        cmd       = c;
        cmd_din   = d;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_din   = ~d;
        trace.delete();
        if (collect) begin
            for (k = 0; k < 3000; k++) begin
                trace.push_back({scl_o, sda_o});
                if (done || al) break;
                @(negedge clk);
            end
            checkOutput({name, "_finished"}, done | al, 1);
        end
    endtask

    // Scoreboard monitor: every done/al pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (rstn && (done || al)) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_event", sb.size(), 1);
            end else begin
                exp_t e;
                e = sb.pop_front();
                checkOutput({e.name, "_al"}, al, e.is_al);
                checkOutput({e.name, "_done"}, done, !e.is_al);
                if (e.chk_dout) checkOutput({e.name, "_dout"}, dout, e.dout);
                checkOutput({e.name, "_owner"}, bus_owner, e.owner);
            end
        end
    end

    initial begin
        // Reset values.
        #12;
        checkOutput("rst_scl", scl_o, 1);
        checkOutput("rst_sda", sda_o, 1);
        checkOutput("rst_ready", cmd_ready, 1);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_al", al, 0);
        checkOutput("rst_owner", bus_owner, 0);
        checkOutput("rst_dout", dout, 0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);

        // 1: START on an idle bus (SCL already high, so no ST1).
        seg(1, 1, 8); seg(1, 0, 8); seg(0, 0, 4); seg(0, 0, 1);
        applyStimulus("start", 2'b00, 0, 1, 0, 0, 0, 1);
        checkTrace("start");

        // 2: WRITE 0 then WRITE 1.
        seg(0, 0, 8); seg(1, 0, 8); seg(0, 0, 1);
        applyStimulus("wr0", 2'b10, 0, 1, 0, 1, 0, 1);
        checkTrace("wr0");
        seg(0, 0, 4); seg(0, 1, 4); seg(1, 1, 8); seg(0, 1, 1);
        applyStimulus("wr1", 2'b10, 1, 1, 0, 1, 1, 1);
        checkTrace("wr1");

        // 3: READ with the slave driving 0, then 1.  SDA stays released.
        resp_low = 1'b1;
        seg(0, 1, 8); seg(1, 1, 8); seg(0, 1, 1);
        applyStimulus("rd0", 2'b11, 0, 1, 0, 1, 0, 1);
        checkTrace("rd0");
        resp_low = 1'b0;
        seg(0, 1, 8); seg(1, 1, 8); seg(0, 1, 1);
        applyStimulus("rd1", 2'b11, 0, 1, 0, 1, 1, 1);
        checkTrace("rd1");

        // 4: clock stretch of 50 cycles once SCL is released in B3.
        stretch = 1'b1;
        fork
            begin
                for (int k = 0; k < 200; k++) begin
                    @(negedge clk);
                    if (scl_o) break;
                end
                repeat (50) @(posedge clk);
                #1 stretch = 1'b0;
            end
        join_none
        seg(0, 1, 4); seg(0, 0, 4); seg(1, 0, 58); seg(0, 0, 1);
        applyStimulus("stretch", 2'b10, 0, 1, 0, 1, 0, 1);
        checkTrace("stretch");
        stretch = 1'b0;

        // 5a: WRITE 1 loses arbitration on the third counted B3 cycle.
        fork
            begin
                for (int k = 0; k < 200; k++) begin
                    @(negedge clk);
                    if (scl_o) break;
                end
                repeat (2) @(posedge clk);
                #1 resp_low = 1'b1;
            end
        join_none
        seg(0, 0, 4); seg(0, 1, 4); seg(1, 1, 4);
        applyStimulus("arb", 2'b10, 1, 1, 1, 0, 0, 0);
        checkTrace("arb");
        resp_low = 1'b0;
        @(negedge clk);
        checkOutput("arb_ready_after", cmd_ready, 1);

        // 5b: START while another master holds the bus.
        bus_busy = 1'b1;
        seg(1, 1, 1);
        applyStimulus("start_busy", 2'b00, 0, 1, 1, 0, 0, 0);
        checkTrace("start_busy");
        bus_busy = 1'b0;

        // 6: START, one bit, repeated START (busy ignored when owner), STOP.
        seg(1, 1, 8); seg(1, 0, 8); seg(0, 0, 4); seg(0, 0, 1);
        applyStimulus("start2", 2'b00, 0, 1, 0, 0, 0, 1);
        checkTrace("start2");
        seg(0, 0, 4); seg(0, 1, 4); seg(1, 1, 8); seg(0, 1, 1);
        applyStimulus("wr1b", 2'b10, 1, 1, 0, 1, 1, 1);
        checkTrace("wr1b");
        bus_busy = 1'b1;
        seg(0, 1, 4); seg(1, 1, 8); seg(1, 0, 8); seg(0, 0, 4); seg(0, 0, 1);
        applyStimulus("rstart", 2'b00, 0, 1, 0, 0, 0, 1);
        checkTrace("rstart");
        seg(0, 0, 4); seg(1, 0, 8); seg(1, 1, 8); seg(1, 1, 1);
        applyStimulus("stop", 2'b01, 0, 1, 0, 0, 0, 0);
        checkTrace("stop");
        bus_busy = 1'b0;

        // Reset asserted in the middle of B2 of a WRITE 0.
        applyStimulus("wr_rst", 2'b10, 0, 0, 0, 0, 0, 0);
        repeat (5) @(negedge clk);
        checkOutput("mid_b2_scl", scl_o, 0);
        checkOutput("mid_b2_sda", sda_o, 0);
        #2 rstn = 1'b0;
        #1;
        checkOutput("rst_mid_scl", scl_o, 1);
        checkOutput("rst_mid_sda", sda_o, 1);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        checkOutput("rst_mid_ready", cmd_ready, 1);
        checkOutput("rst_mid_owner", bus_owner, 0);

        // Zero phase lengths still give one-cycle phases.
        t_half_low = '0;
        t_high     = '0;
        seg(0, 1, 2); seg(1, 1, 1); seg(0, 1, 1);
        applyStimulus("wr_t0", 2'b10, 1, 1, 0, 1, 1, 0);
        checkTrace("wr_t0");

        repeat (5) @(negedge clk);
        checkOutput("sb_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/i2c_phy_master.md
Name: i2c_phy_master

Overview:
- Bit-level I2C bus driver: the transmit end of the bus PHY, complementing the filtered receiver/debouncer.
- Executes one command at a time (START/repeated START, STOP, WRITE bit, READ bit) by sequencing scl_o/sda_o open-drain enables.
- Reads back bus state through the receiver's filtered scl_i/sda_i.
- Supports clock stretching and arbitration-loss detection. Sits between the byte-level controller and the PHY pads.

Parameters:
- CNT_W, 16, width of phase-timing inputs and internal phase counter.

Ports:
- clk  input  1  system clock
- rstn  input  1  asynchronous active-low reset
- cmd_valid  input  1  command request
- cmd_ready  output  1  block idle, command accepted when cmd_valid && cmd_ready
- cmd  input  2  00 START, 01 STOP, 10 WRITE, 11 READ
- cmd_din  input  1  bit to drive for WRITE
- done  output  1  one-cycle pulse, command completed
- dout  output  1  bit sampled by READ/WRITE
- al  output  1  one-cycle pulse, arbitration lost
- bus_owner  output  1  this master holds the bus (START done, no STOP/al since)
- t_half_low  input  CNT_W  half of SCL low period, clk cycles
- t_high  input  CNT_W  SCL high period and START/STOP setup/hold, clk cycles
- bus_busy  input  1  bus busy flag from receiver
- scl_i  input  1  filtered SCL
- sda_i  input  1  filtered SDA
- scl_o  output  1  1 = release SCL, 0 = pull low
- sda_o  output  1  1 = release SDA, 0 = pull low

Behaviour:
- Reset (async, immediate):
  - scl_o=1, sda_o=1; lines are released even mid-bit.
  - done=0, al=0, dout=0, bus_owner=0; state IDLE, so cmd_ready=1.
- Timing:
  - cmd_ready=1 only in IDLE.
  - Accepted command enters its first phase the next cycle.
  - Each timed phase lasts max(T,1) cycles, where T is the sampled t_half_low or t_high.
  - Timing inputs are sampled at phase entry; changes mid-phase are ignored.
- Between commands scl_o/sda_o hold their last values. After START/WRITE/READ, SCL is left low.
- "Wait-high":
  - Release scl_o, then stall until scl_i==1 (clock stretching, unbounded).
  - The t_high count starts on the first cycle scl_i==1.
- START:
  - If bus_owner==0 && bus_busy==1 at acceptance: al pulse, no line change, return to IDLE, no done.
  - ST1 (only if scl_o==0 at acceptance): scl_o=0, sda_o=1, t_half_low.
  - ST2: wait-high with sda_o=1, t_high.
  - ST3: sda_o=0, t_high.
  - ST4: scl_o=0, t_half_low.
  - Then done, bus_owner=1.
- STOP:
  - SP1: scl_o=0, sda_o=0, t_half_low.
  - SP2: wait-high, t_high.
  - SP3: sda_o=1, t_high.
  - Then done, bus_owner=0.
- WRITE/READ:
  - B1: scl_o=0, sda_o unchanged (hold), t_half_low.
  - B2: scl_o=0, sda_o = cmd_din for WRITE, 1 for READ, t_half_low.
  - B3: wait-high, t_high.
  - Last B3 cycle: dout <= sda_i. Next cycle: scl_o=0, done.
- Arbitration loss:
  - Trigger: any counted B3 cycle with sda_o==1 && sda_i==0 during WRITE, or any SP3 cycle with sda_i==0.
  - Response next cycle: al pulse, scl_o=1, sda_o=1, bus_owner=0, IDLE, no done.
  - READ never raises al.
- cmd_din is captured at acceptance.
- STOP/WRITE/READ with bus_owner==0 execute normally; sequencing legality is the upper layer's responsibility.
- done and al are mutually exclusive and never asserted in the acceptance cycle.

Test Plan:
1. Idle bus, bus_busy=0, t_half_low=4, t_high=8, START -> scl_o stays 1 for ST2 (8 cycles); sda_o=0 for exactly 8 cycles before scl_o falls; scl_o low 4 cycles; done pulse; bus_owner=1.
2. After START, WRITE din=0 then din=1 -> each bit has scl_o low 8 cycles; sda_o changes only after the first 4 low cycles; scl_o high 8 cycles; done per bit; dout equals the driven bit; al=0.
3. READ with responder holding sda_i=0, then READ with sda_i=1 -> dout=0 then dout=1; sda_o stays 1 throughout both.
4. Clock stretch: hold scl_i low 50 cycles after scl_o release in B3 -> high count starts when scl_i rises; scl_o high exactly 8 cycles after that; done follows.
5. Arbitration: WRITE din=1 with sda_i forced 0 at the 3rd counted B3 cycle -> al pulse next cycle; scl_o=sda_o=1; bus_owner=0; no done; cmd_ready=1. Separately, START with bus_busy=1 and bus_owner=0 -> al, lines untouched.
6. STOP after a bit -> sda_o rises 8 cycles after scl_i high; done; bus_owner=0. Assert rstn low mid-B2 -> scl_o=sda_o=1 immediately, cmd_ready=1 after release.
